// File: rtl/dot_row_feeder.sv
// Row sequencer for the 784-element dot-product engine: preloads, streams 28 rows per neuron, captures results.
// Optional running signed argmax over the captured results when DOT_ARGMAX_EN is defined.
module dot_row_feeder #(
  parameter int NEURONS     = 10,
  parameter int ROWS        = 28,
  parameter int LANES       = 28,
  parameter int HOLD        = 7,
  parameter int RESULT_CNT  = 283,
  parameter int PIXEL_SIZE  = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int VALUE_SIZE  = 26
) (
  input  logic                           clk,
  input  logic                           GlobalReset,
  input  logic                           start,
  output logic                           busy,
  output logic                           rd_en,
  output logic [4:0]                     pix_addr,
  output logic [8:0]                     wgt_addr,
  input  logic [LANES*PIXEL_SIZE-1:0]    rd_pixels,
  input  logic [LANES*WEIGHT_SIZE-1:0]   rd_weights,
  output logic                           eng_rst_n,
  output logic [LANES*PIXEL_SIZE-1:0]    eng_pixels,
  output logic [LANES*WEIGHT_SIZE-1:0]   eng_weights,
  input  logic [VALUE_SIZE-1:0]          eng_value,
  output logic [VALUE_SIZE-1:0]          result,
  output logic [3:0]                     result_idx,
  output logic                           result_valid,
`ifdef DOT_ARGMAX_EN
  output logic [3:0]                     best_idx,
  output logic [VALUE_SIZE-1:0]          best_value,
`endif
  output logic                           done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELOAD,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [2:0] PH_LAST  = 3'(HOLD - 1);
  localparam logic [2:0] PH_PF    = 3'(HOLD - 2);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);
  localparam logic [8:0] CNT_END  = 9'(RESULT_CNT);
  localparam logic [8:0] ROWS9    = 9'(ROWS);
  localparam logic [3:0] N_LAST   = 4'(NEURONS - 1);

  state_t     state, state_nxt;
  logic [1:0] pcnt;
  logic [8:0] cnt;
  logic [2:0] ph;
  logic [4:0] row;
  logic [3:0] n;
  logic [8:0] wgt_base;
  logic       vld_p1;
  logic       start_acc;

  assign start_acc = (state == S_IDLE) && start;

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) state <= S_IDLE;
    else              state <= state_nxt;
  end

  // Read requests are issued one cycle ahead of the cycle whose closing edge loads the engine registers.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    pix_addr  = 5'd0;
    wgt_addr  = 9'd0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_PRELOAD;
      end
      S_PRELOAD: begin
        if (pcnt == 2'd0) begin
          rd_en    = 1'b1;
          wgt_addr = wgt_base;
        end
        if (pcnt == 2'd2) state_nxt = S_RUN;
      end
      S_RUN: begin
        if ((ph == PH_PF) && (row != ROW_LAST)) begin
          rd_en    = 1'b1;
          pix_addr = row + 5'd1;
          wgt_addr = wgt_base + {4'd0, row} + 9'd1;
        end
        if (cnt == CNT_END) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        state_nxt = (n == N_LAST) ? S_DONE : S_PRELOAD;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      busy         <= 1'b0;
      pcnt         <= 2'd0;
      cnt          <= 9'd0;
      ph           <= 3'd0;
      row          <= 5'd0;
      n            <= 4'd0;
      wgt_base     <= 9'd0;
      vld_p1       <= 1'b0;
      eng_rst_n    <= 1'b0;
      result       <= '0;
      result_idx   <= 4'd0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      vld_p1       <= rd_en;
      eng_rst_n    <= (state_nxt == S_RUN);
      case (state)
        S_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            n        <= 4'd0;
            wgt_base <= 9'd0;
            pcnt     <= 2'd0;
          end
        end
        S_PRELOAD: begin
          pcnt <= pcnt + 2'd1;
          cnt  <= 9'd0;
          ph   <= 3'd0;
          row  <= 5'd0;
        end
        S_RUN: begin
          if (cnt != 9'h1FF) cnt <= cnt + 9'd1;
          if (ph == PH_LAST) begin
            ph <= 3'd0;
            if (row != ROW_LAST) row <= row + 5'd1;
          end else begin
            ph <= ph + 3'd1;
          end
          if (cnt == CNT_END) begin
            result       <= eng_value;
            result_idx   <= n;
            result_valid <= 1'b1;
          end
        end
        S_NEXT: begin
          pcnt <= 2'd0;
          if (n != N_LAST) begin
            n        <= n + 4'd1;
            wgt_base <= wgt_base + ROWS9;
          end
        end
        S_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  // p1: row-buffer data returns one cycle after rd_en and is registered towards the engine.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      eng_pixels  <= '0;
      eng_weights <= '0;
    end else if (vld_p1) begin
      eng_pixels  <= rd_pixels;
      eng_weights <= rd_weights;
    end
  end

`ifdef DOT_ARGMAX_EN
  logic signed [VALUE_SIZE-1:0] run_val;
  logic [3:0]                   run_idx;

  // The running max is folded in at capture; the outputs only move when the job completes.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      run_val    <= '0;
      run_idx    <= 4'd0;
      best_value <= '0;
      best_idx   <= 4'd0;
    end else if (start_acc) begin
      run_val    <= '0;
      run_idx    <= 4'd0;
      best_value <= '0;
      best_idx   <= 4'd0;
    end else begin
      if ((state == S_RUN) && (cnt == CNT_END)) begin
        if ((n == 4'd0) || ($signed(eng_value) > run_val)) begin
          run_val <= $signed(eng_value);
          run_idx <= n;
        end
      end
      if ((state == S_NEXT) && (n == N_LAST)) begin
        best_value <= run_val;
        best_idx   <= run_idx;
      end
    end
  end
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_dot_row_feeder.sv
// Scoreboard bench for dot_row_feeder with row-buffer and behavioural engine models.
// Define DOT_ARGMAX_EN to also exercise the argmax outputs.
module tb_dot_row_feeder;

  localparam int LANES = 28;
  localparam int PS    = 10;
  localparam int WS    = 19;
  localparam int VS    = 26;

  logic                clk;
  logic                GlobalReset;
  logic                start;
  logic                busy;
  logic                rd_en;
  logic [4:0]          pix_addr;
  logic [8:0]          wgt_addr;
  logic [LANES*PS-1:0] rd_pixels;
  logic [LANES*WS-1:0] rd_weights;
  logic                eng_rst_n;
  logic [LANES*PS-1:0] eng_pixels;
  logic [LANES*WS-1:0] eng_weights;
  logic [VS-1:0]       eng_value;
  logic [VS-1:0]       result;
  logic [3:0]          result_idx;
  logic                result_valid;
  logic                done;
`ifdef DOT_ARGMAX_EN
  logic [3:0]          best_idx;
  logic [VS-1:0]       best_value;
`endif

  dot_row_feeder dut (
    .clk(clk),
    .GlobalReset(GlobalReset),
    .start(start),
    .busy(busy),
    .rd_en(rd_en),
    .pix_addr(pix_addr),
    .wgt_addr(wgt_addr),
    .rd_pixels(rd_pixels),
    .rd_weights(rd_weights),
    .eng_rst_n(eng_rst_n),
    .eng_pixels(eng_pixels),
    .eng_weights(eng_weights),
    .eng_value(eng_value),
    .result(result),
    .result_idx(result_idx),
    .result_valid(result_valid),
`ifdef DOT_ARGMAX_EN
    .best_idx(best_idx),
    .best_value(best_value),
`endif
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Row buffer: pixel lanes carry the row index, weight lanes the weight address; garbage otherwise.
  always @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      rd_pixels[l*PS +: PS]  <= rd_en ? {5'd0, pix_addr} : 10'h3FF;
      rd_weights[l*WS +: WS] <= rd_en ? {10'd0, wgt_addr} : 19'h7FFFF;
    end
  end

  // Engine: counts released cycles, presents the neuron's value only at cycle 283.
  logic [VS-1:0] val_tab [16];
  int            ecnt = 0;
  int            em_n = 0;
  logic          prev_eng = 1'b0;

  always @(posedge clk) begin
    ecnt     <= eng_rst_n ? ecnt + 1 : 0;
    prev_eng <= eng_rst_n;
    if (!busy)                      em_n <= 0;
    else if (prev_eng && !eng_rst_n) em_n <= em_n + 1;
  end

  assign eng_value = (eng_rst_n && ecnt == 283 && em_n < 16) ? val_tab[em_n] : 26'h2AAAAAA;

  typedef struct {
    bit            is_done;
    logic [VS-1:0] val;
    int            idx;
  } exp_t;
  exp_t exp_q[$];

  int wexp   = 0;
  int hi_run = 0;
  int lo_run = 0;
  bit prev_rv = 1'b0;

  // Monitor
  always @(negedge clk) begin
    if (!GlobalReset) begin
      exp_q.delete();
      wexp    = 0;
      hi_run  = 0;
      lo_run  = 0;
      prev_rv = 1'b0;
    end else begin
      if (!busy) wexp = 0;
      if (rd_en) begin
        chk("rd_en_while_busy", busy, 1);
        chk("wgt_addr", wgt_addr, wexp);
        chk("pix_addr", pix_addr, wexp % 28);
        wexp++;
      end
      if (eng_rst_n) begin
        int r;
        if (hi_run == 0) chk("eng_rst_low_gap_ge2", lo_run >= 2, 1);
        r = hi_run / 7;
        if (r > 27) r = 27;
        chk("eng_pix_lane0", eng_pixels[9:0], r);
        chk("eng_pix_lane27", eng_pixels[279:270], r);
        chk("eng_wgt_lane0", eng_weights[18:0], em_n * 28 + r);
        hi_run++;
        lo_run = 0;
      end else begin
        if (hi_run != 0) chk("eng_rst_high_len", hi_run, 284);
        hi_run = 0;
        lo_run++;
      end
      if (result_valid) begin
        chk("result_expected", exp_q.size() > 0, 1);
        chk("rv_single_cycle", prev_rv, 0);
        chk("busy_at_result", busy, 1);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_not_done", e.is_done, 0);
          chk("result_value", result, e.val);
          chk("result_idx", result_idx, e.idx);
        end
      end
      if (done) begin
        chk("done_expected", exp_q.size() > 0, 1);
        chk("done_after_last_rv", prev_rv, 1);
        chk("busy_at_done", busy, 1);
        chk("reads_per_job", wexp, 280);
        if (exp_q.size() > 0) begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_order", e.is_done, 1);
        end
      end
      prev_rv = result_valid;
    end
  end

  task automatic push_job();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      e.is_done = 1'b0;
      e.val     = val_tab[i];
      e.idx     = i;
      exp_q.push_back(e);
    end
    e.is_done = 1'b1;
    e.val     = '0;
    e.idx     = 0;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_within_budget", seen, 1);
  endtask

  task automatic wait_cnt(input int nn, input int kk);
    bit seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (em_n == nn && eng_rst_n && ecnt == kk) seen = 1'b1;
    end
    chk("reach_neuron_cnt", seen, 1);
  endtask

  task automatic idle_quiet(input string tag, input int cyc);
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_done"}, done, 0);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_eng_rst_n"}, eng_rst_n, 0);
    chk({tag, "_result"}, result, 0);
    chk({tag, "_result_idx"}, result_idx, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wgt_addr"}, wgt_addr, 0);
    chk({tag, "_eng_pix"}, eng_pixels[63:0], 0);
    chk({tag, "_eng_wgt"}, eng_weights[63:0], 0);
  endtask

  initial begin
    GlobalReset = 1'b0;
    start       = 1'b0;
    for (int i = 0; i < 16; i++) val_tab[i] = 26'h0ABCDE;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    GlobalReset = 1'b1;
    repeat (2) @(negedge clk);

    // Job A: constant result, start pulses in RUN and in the done cycle are ignored.
    push_job();
    do_start();
    wait_cnt(1, 50);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(4000);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("result_holds", result, 26'h0ABCDE);
    chk("result_idx_holds", result_idx, 9);
    idle_quiet("after_done", 12);

    // Job B: asynchronous reset during neuron 4 at cnt 100.
    push_job();
    do_start();
    wait_cnt(4, 100);
    #1 GlobalReset = 1'b0;
    #1 chk_zero("midjob_reset");
    repeat (3) @(negedge clk);
    GlobalReset = 1'b1;
    idle_quiet("after_abort", 20);

    // Job C: signed values with ties; restarts at neuron 0.
    val_tab[0] = 26'h3FFFFFB;
    val_tab[1] = 26'd7;
    val_tab[2] = 26'd7;
    val_tab[3] = 26'd3;
    for (int i = 4; i < 16; i++) val_tab[i] = 26'd0;
    push_job();
    do_start();
    wait_done(4000);
`ifdef DOT_ARGMAX_EN
    chk("best_idx_at_done", best_idx, 1);
    chk("best_value_at_done", best_value, 26'd7);
    @(negedge clk);
    chk("best_idx_held", best_idx, 1);
    chk("best_value_held", best_value, 26'd7);
`endif
    idle_quiet("end", 5);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
